// File: rtl/game_pkg.sv
// Shared constants, pixel type, palette and line-setup state encoding for the box renderer.
package game_pkg;

  localparam int N     = 8;
  localparam int BOX_W = 48;
  localparam int BOX_H = 32;

  typedef logic [5:0] rgb_t;

  localparam rgb_t OUTLINE_RGB = 6'b111111;

  localparam rgb_t PALETTE [8] = '{
    6'b000000, 6'b110000, 6'b001100, 6'b000011,
    6'b111100, 6'b110011, 6'b001111, 6'b101010
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_READY = 2'd2
  } line_state_t;

endpackage

// File: rtl/box_hit.sv
// One box's horizontal coverage and 1-px outline detection for the current pixel.
module box_hit #(
  parameter int HIT_W = 48,
  parameter int HIT_H = 32
) (
  input  logic       i_en,
  input  logic [9:0] i_posx,
  input  logic [8:0] i_posy,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_line,
  output logic       o_hit,
  output logic       o_edge
);
  import game_pkg::*;

  logic [10:0] w_x0;
  logic [10:0] w_x1;
  logic [10:0] w_h;
  logic [9:0]  w_y0;
  logic        w_row_edge;

  // x range is compared at 11 bits so posx + width never wraps near the right border
  assign w_x0       = {1'b0, i_posx};
  assign w_x1       = w_x0 + 11'(HIT_W);
  assign w_h        = {1'b0, i_hpos};
  assign w_y0       = {1'b0, i_posy};
  assign w_row_edge = (i_line == w_y0) || (i_line == w_y0 + 10'(HIT_H - 1));
  assign o_hit      = i_en && (w_h >= w_x0) && (w_h < w_x1);
  assign o_edge     = (w_h == w_x0) || (w_h == w_x1 - 11'd1) || w_row_edge;

endmodule

// File: rtl/box_renderer.sv
// Per-line box renderer: snapshots box positions each frame, scans one box per cycle
// during hblank to build a row mask, then colours pixels through a 2-stage pipeline.
module box_renderer #(
  parameter int         SCREEN_W = 640,
  parameter int         SCREEN_H = 480,
  parameter int         BOX_W    = game_pkg::BOX_W,
  parameter int         BOX_H    = game_pkg::BOX_H,
  parameter int         N        = game_pkg::N,
  parameter logic [5:0] BG_RGB   = 6'b000001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic [N*10-1:0]      posx_flat,
  input  logic [N*9-1:0]       posy_flat,
  input  logic [N*3-1:0]       color_flat,
  input  logic                 line_start,
  input  logic [9:0]           next_line,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 video_on,
  output logic [5:0]           rgb,
  output logic                 box_valid,
  output logic [$clog2(N)-1:0] box_id,
  output logic                 line_ready
);
  import game_pkg::*;

  localparam int             KW    = $clog2(N);
  localparam logic [KW:0]    K_END = (KW + 1)'(N);

  logic                 r_ft_d1;
  logic [N*10-1:0]      r_posx_s;
  logic [N*9-1:0]       r_posy_s;
  logic [N*3-1:0]       r_color_s;
  line_state_t          r_state;
  logic [9:0]           r_line;
  logic [KW:0]          r_k;
  logic [N-1:0]         r_shadow;
  logic [N-1:0]         r_row_mask;
  logic [9:0]           r_mask_line;
  logic                 r_line_ready;
  logic [9:0]           r_hpos_p1;
  logic                 r_von_p1;
  logic [9:0]           r_line_p1;
  logic [5:0]           r_rgb_p2;
  logic                 r_valid_p2;
  logic [KW-1:0]        r_id_p2;

  logic [KW-1:0]        w_kidx;
  logic [9:0]           w_ky;
  logic                 w_scan_hit;
  logic [N-1:0]         w_hit;
  logic [N-1:0]         w_edge;
  logic                 w_win;
  logic [KW-1:0]        w_id;
  logic [5:0]           w_rgb;
  logic                 w_unused_vpos;

  // the row is tracked internally, so the timing block's vpos is not needed
  assign w_unused_vpos = ^vpos;

  // vertical test for the box currently addressed by the scan counter
  assign w_kidx     = r_k[KW-1:0];
  assign w_ky       = {1'b0, r_posy_s[w_kidx*9 +: 9]};
  assign w_scan_hit = (w_ky <= r_line) && (r_line < w_ky + 10'(BOX_H));

  // delay frame_tick one cycle and snapshot the post-update box state for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ft_d1   <= 1'b0;
      r_posx_s  <= '0;
      r_posy_s  <= '0;
      r_color_s <= '0;
    end else begin
      r_ft_d1 <= frame_tick;
      if (r_ft_d1) begin
        r_posx_s  <= posx_flat;
        r_posy_s  <= posy_flat;
        r_color_s <= color_flat;
      end
    end
  end

  // line-setup FSM: one box per cycle into the shadow mask, then publish as row_mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_line       <= '0;
      r_k          <= '0;
      r_shadow     <= '0;
      r_row_mask   <= '0;
      r_mask_line  <= '0;
      r_line_ready <= 1'b0;
    end else if (line_start) begin
      r_state      <= ST_SCAN;
      r_line       <= next_line;
      r_k          <= '0;
      r_shadow     <= '0;
      r_line_ready <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      if (r_k < K_END) begin
        r_shadow[w_kidx] <= w_scan_hit;
        r_k              <= r_k + 1'b1;
      end else begin
        r_row_mask   <= (r_line >= 10'(SCREEN_H)) ? '0 : r_shadow;
        r_mask_line  <= r_line;
        r_line_ready <= 1'b1;
        r_state      <= ST_READY;
      end
    end
  end

  // stage 1: register pixel position, visibility and the row the mask belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hpos_p1 <= '0;
      r_von_p1  <= 1'b0;
      r_line_p1 <= '0;
    end else begin
      r_hpos_p1 <= hpos;
      r_von_p1  <= video_on && (hpos < 10'(SCREEN_W));
      r_line_p1 <= r_mask_line;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_hit
      box_hit #(.HIT_W(BOX_W), .HIT_H(BOX_H)) u_hit (
        .i_en   (r_row_mask[g]),
        .i_posx (r_posx_s[g*10 +: 10]),
        .i_posy (r_posy_s[g*9 +: 9]),
        .i_hpos (r_hpos_p1),
        .i_line (r_line_p1),
        .o_hit  (w_hit[g]),
        .o_edge (w_edge[g])
      );
    end
  endgenerate

  // priority select: walking downward lets the lowest covering index win
  always_comb begin
    w_win = 1'b0;
    w_id  = '0;
    w_rgb = BG_RGB;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_win = 1'b1;
        w_id  = KW'(k);
        w_rgb = w_edge[k] ? OUTLINE_RGB : PALETTE[r_color_s[k*3 +: 3]];
      end
    end
  end

  // stage 2: register final colour, blanking to black outside the visible area
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb_p2   <= '0;
      r_valid_p2 <= 1'b0;
      r_id_p2    <= '0;
    end else if (!r_von_p1) begin
      r_rgb_p2   <= '0;
      r_valid_p2 <= 1'b0;
      r_id_p2    <= '0;
    end else begin
      r_rgb_p2   <= w_rgb;
      r_valid_p2 <= w_win;
      r_id_p2    <= w_win ? w_id : '0;
    end
  end

  assign rgb        = r_rgb_p2;
  assign box_valid  = r_valid_p2;
  assign box_id     = r_id_p2;
  assign line_ready = r_line_ready;

endmodule

// File: tb/tb_box_renderer.sv
// Directed bench for box_renderer with a pixel scoreboard and a small reference model.
module tb_box_renderer;
  import game_pkg::*;

  localparam logic [5:0] BG = 6'b000001;
  localparam logic [5:0] WH = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic [79:0] posx_flat;
  logic [71:0] posy_flat;
  logic [23:0] color_flat;
  logic        line_start;
  logic [9:0]  next_line;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        video_on;
  logic [5:0]  rgb;
  logic        box_valid;
  logic [2:0]  box_id;
  logic        line_ready;

  box_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .posx_flat  (posx_flat),
    .posy_flat  (posy_flat),
    .color_flat (color_flat),
    .line_start (line_start),
    .next_line  (next_line),
    .hpos       (hpos),
    .vpos       (vpos),
    .video_on   (video_on),
    .rgb        (rgb),
    .box_valid  (box_valid),
    .box_id     (box_id),
    .line_ready (line_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] rgb;
    logic       v;
    logic [2:0] id;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   bx[8], by[8], bc[8];
  int   sx[8], sy[8], sc[8];
  int   m_line;
  bit   m_mask_ok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input int x, input bit von);
    exp_t e;
    e.tag = tag; e.rgb = 6'd0; e.v = 1'b0; e.id = 3'd0;
    if (!von) return e;
    e.rgb = BG;
    if (!m_mask_ok || m_line >= 480) return e;
    for (int k = 0; k < 8; k++) begin
      if (sy[k] <= m_line && m_line < sy[k] + 32 && sx[k] <= x && x < sx[k] + 48) begin
        e.v  = 1'b1;
        e.id = 3'(k);
        if (x == sx[k] || x == sx[k] + 47 || m_line == sy[k] || m_line == sy[k] + 31)
          e.rgb = WH;
        else
          e.rgb = PALETTE[sc[k]];
        return e;
      end
    end
    return e;
  endfunction

  task automatic pix_exp(input int x, input bit von, input exp_t e);
    exp_t got;
    @(negedge clk);
    hpos = 10'(x);
    video_on = von;
    sbq.push_back(e);
    @(negedge clk);
    @(negedge clk);
    got = sbq.pop_front();
    chk({got.tag, ".rgb"}, 32'(rgb), 32'(got.rgb));
    chk({got.tag, ".valid"}, 32'(box_valid), 32'(got.v));
    chk({got.tag, ".id"}, 32'(box_id), 32'(got.id));
  endtask

  task automatic pix(input string tag, input int x, input bit von);
    pix_exp(x, von, model(tag, x, von));
  endtask

  task automatic pixc(input string tag, input int x, input bit von,
                      input logic [5:0] r, input logic v, input logic [2:0] id);
    exp_t e;
    e.tag = tag; e.rgb = r; e.v = v; e.id = id;
    pix_exp(x, von, e);
  endtask

  task automatic load_boxes();
    for (int k = 0; k < 8; k++) begin
      posx_flat[k*10 +: 10] = 10'(bx[k]);
      posy_flat[k*9 +: 9]   = 9'(by[k]);
      color_flat[k*3 +: 3]  = 3'(bc[k]);
    end
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      sx[k] = bx[k]; sy[k] = by[k]; sc[k] = bc[k];
    end
  endtask

  task automatic wait_ready(input string tag);
    int lat;
    lat = 0;
    while (line_ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, 32'(lat), 32'd9);
  endtask

  task automatic scan(input int n);
    @(negedge clk);
    line_start = 1'b1;
    next_line  = 10'(n);
    @(negedge clk);
    line_start = 1'b0;
    wait_ready($sformatf("lat_line%0d", n));
    m_line = n;
    m_mask_ok = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; line_start = 1'b0; next_line = '0;
    hpos = '0; vpos = '0; video_on = 1'b1;
    posx_flat = '0; posy_flat = '0; color_flat = '0;
    m_line = 0; m_mask_ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bx[k] = 600; by[k] = 500; bc[k] = 0; sx[k] = 0; sy[k] = 0; sc[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst.rgb", 32'(rgb), 32'd0);
    chk("rst.valid", 32'(box_valid), 32'd0);
    chk("rst.id", 32'(box_id), 32'd0);
    chk("rst.ready", 32'(line_ready), 32'd0);
    rst_n = 1'b1;
    pix("pre_scan", 120, 1'b1);

    // single box, basic colour and latency
    bx[0] = 100; by[0] = 50; bc[0] = 2;
    load_boxes();
    scan(60);
    pixc("b0_fill", 120, 1'b1, PALETTE[2], 1'b1, 3'd0);
    pix("b0_left_out", 99, 1'b1);
    pixc("b0_left_edge", 100, 1'b1, WH, 1'b1, 3'd0);
    pix("b0_right_edge", 147, 1'b1);
    pixc("b0_right_out", 148, 1'b1, BG, 1'b0, 3'd0);

    // overlap priority
    bx[0] = 200; by[0] = 100; bc[0] = 1;
    bx[3] = 200; by[3] = 100; bc[3] = 4;
    load_boxes();
    scan(110);
    pixc("ovl_low_wins", 210, 1'b1, PALETTE[1], 1'b1, 3'd0);
    by[0] = 300;
    load_boxes();
    scan(110);
    pixc("ovl_box3", 210, 1'b1, PALETTE[4], 1'b1, 3'd3);

    // box at origin: outline rows and columns
    bx[3] = 600; by[3] = 500;
    bx[0] = 0; by[0] = 0; bc[0] = 5;
    load_boxes();
    scan(0);
    pixc("l0_x0", 0, 1'b1, WH, 1'b1, 3'd0);
    pixc("l0_x20", 20, 1'b1, WH, 1'b1, 3'd0);
    pixc("l0_x47", 47, 1'b1, WH, 1'b1, 3'd0);
    pixc("l0_x48", 48, 1'b1, BG, 1'b0, 3'd0);
    scan(1);
    pixc("l1_x0", 0, 1'b1, WH, 1'b1, 3'd0);
    pixc("l1_x1", 1, 1'b1, PALETTE[5], 1'b1, 3'd0);
    pixc("l1_x46", 46, 1'b1, PALETTE[5], 1'b1, 3'd0);
    pixc("l1_x47", 47, 1'b1, WH, 1'b1, 3'd0);
    pix("l1_x48", 48, 1'b1);

    // restarted scan: mask must reflect the second line only
    bx[0] = 600; by[0] = 500;
    bx[1] = 300; by[1] = 50;  bc[1] = 3;
    bx[2] = 300; by[2] = 190; bc[2] = 6;
    load_boxes();
    @(negedge clk);
    line_start = 1'b1; next_line = 10'd60;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("restart.ready_low", 32'(line_ready), 32'd0);
    line_start = 1'b1; next_line = 10'd200;
    @(negedge clk);
    line_start = 1'b0;
    wait_ready("restart.lat");
    m_line = 200;
    pixc("restart_mask", 310, 1'b1, PALETTE[6], 1'b1, 3'd2);

    // off-screen line and blanking
    by[1] = 470;
    load_boxes();
    scan(480);
    pixc("offscreen", 310, 1'b1, BG, 1'b0, 3'd0);
    scan(200);
    pixc("blank", 310, 1'b0, 6'd0, 1'b0, 3'd0);
    pix("unblank", 310, 1'b1);

    // reset in the middle of a scan
    @(negedge clk);
    line_start = 1'b1; next_line = 10'd200;
    @(negedge clk);
    line_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.rgb", 32'(rgb), 32'd0);
    chk("midrst.valid", 32'(box_valid), 32'd0);
    chk("midrst.id", 32'(box_id), 32'd0);
    chk("midrst.ready", 32'(line_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_mask_ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sx[k] = 0; sy[k] = 0; sc[k] = 0;
    end
    repeat (12) @(negedge clk);
    chk("midrst.idle", 32'(line_ready), 32'd0);
    pixc("midrst.bg", 310, 1'b1, BG, 1'b0, 3'd0);
    pix("midrst.bg0", 10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
